score_tone_seq: RTL and testbench
=================================

SCORE_TONE_SEQ -- requirements
Module: score_tone_seq

Interface
REQ-001 The block SHALL have parameter NOTE_CYC, default 15000000, meaning clock cycles each note sounds.
REQ-002 The block SHALL have parameter GAP_CYC, default 5000000, meaning silent clock cycles after each note.
REQ-003 The block SHALL have parameters DIV_C5=95556, DIV_E5=75843, DIV_G5=63776 and DIV_C6=47778, each a 17-bit audio half-period in clock cycles.
REQ-004 clk  input  1  single system clock; all state changes on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 units  input  4  BCD units digit of the win score from the upstream win counter.
REQ-007 tens  input  4  BCD tens digit of the win score from the same counter.
REQ-008 mute  input  1  level; forces audio low without altering sequencing.
REQ-009 audio  output  1  square-wave speaker drive.
REQ-010 note_div  output  17  half-period of the note currently sounding; 0 when silent.
REQ-011 busy  output  1  high while a sequence is in PLAY or GAP.
REQ-012 seq_done  output  1  one-cycle pulse when a sequence finishes.

Function
REQ-013 The block SHALL register {tens,units} every cycle as prev_score and SHALL hold a primed flag.
REQ-014 The block SHALL set primed one cycle after rst deasserts; that first cycle loads prev_score and SHALL NOT raise an event.
REQ-015 A score event SHALL be raised when primed=1 and {tens,units} differs from prev_score.
REQ-016 An event whose new score is 21 (tens=2, units=1) SHALL select the victory sequence C5,E5,G5,C6; any other event SHALL select the point sequence C5,E5.
REQ-017 The FSM SHALL have states IDLE, PLAY and GAP.
REQ-018 IDLE->PLAY SHALL occur on the cycle after an event, starting at note index 0.
REQ-019 PLAY SHALL last exactly NOTE_CYC cycles and then enter GAP.
REQ-020 GAP SHALL last exactly GAP_CYC cycles, then advance to the next note in PLAY; after the last note it SHALL return to IDLE with seq_done high for exactly that one transition cycle.
REQ-021 A point event arriving while busy SHALL be ignored.
REQ-022 A victory event arriving while busy SHALL abort the current sequence and restart the victory sequence at index 0 in PLAY on the next cycle; seq_done SHALL NOT pulse for the aborted sequence.
REQ-023 If an event coincides with seq_done, the event SHALL start its sequence on the next cycle.
REQ-024 In PLAY, a half-period counter SHALL count 0..note_div-1 and toggle an internal tone bit at each wrap, giving a toggle every note_div cycles.
REQ-025 On PLAY entry the tone bit and counter SHALL clear to 0.
REQ-026 audio SHALL equal the tone bit AND NOT mute; in IDLE and GAP, audio=0 and note_div=0.
REQ-027 Duration and divider counters SHALL be wide enough for the parameter values without overflow; the note index SHALL be 2 bits.

Reset
REQ-028 While rst=1, the block SHALL hold: state=IDLE, audio=0, note_div=0, busy=0, seq_done=0, primed=0, and all counters and the note index at 0.
REQ-029 rst asserted mid-sequence SHALL abort it immediately and asynchronously, with no seq_done pulse.

Verification
REQ-030 Scenario (NOTE_CYC=8, GAP_CYC=4): score 04->05 -> busy rises next cycle; note_div=95556 for 8 cycles, 0 for 4 cycles, 75843 for 8 cycles, 0 for 4 cycles; seq_done pulses once; busy then falls.
REQ-031 Scenario: score 20->21 -> note_div sequence is 95556, 75843, 63776, 47778, each 8 cycles separated by 4-cycle gaps; seq_done pulses once at the end.
REQ-032 Scenario: point sequence at its second note, then score 20->21 -> victory restarts at C5 on the next cycle; no seq_done pulse for the aborted point sequence.
REQ-033 Scenario: reset released with inputs at 07 -> no event and busy stays 0; a later change 07->08 -> point sequence plays.
REQ-034 Scenario: DIV_C5=3, mute=0 -> audio toggles every 3 cycles during the note; with mute=1 -> audio stays 0 while note_div and seq_done timing are unchanged.
REQ-035 Scenario: rst pulsed during GAP -> all outputs go to 0 immediately; no seq_done pulse.

Source files
------------

// File: rtl/score_tone_seq_if.sv
// score_tone_seq_if: score digits and mute in; audio, note_div, busy, seq_done out
interface score_tone_seq_if;
  logic [3:0] units;
  logic [3:0] tens;
  logic mute;
  logic audio;
  logic [16:0] note_div;
  logic busy;
  logic seq_done;
  modport master(output units, tens, mute, input audio, note_div, busy, seq_done);
  modport slave(input units, tens, mute, output audio, note_div, busy, seq_done);
endinterface

// File: rtl/score_tone_seq.sv
// score_tone_seq: plays C5,E5 on a score change or C5,E5,G5,C6 on reaching 21; ports clk, rst (async high), bus (units/tens/mute in, audio/note_div/busy/seq_done out)
module score_tone_seq #(
  parameter int unsigned NOTE_CYC = 15000000,
  parameter int unsigned GAP_CYC = 5000000,
  parameter logic [16:0] DIV_C5 = 17'd95556,
  parameter logic [16:0] DIV_E5 = 17'd75843,
  parameter logic [16:0] DIV_G5 = 17'd63776,
  parameter logic [16:0] DIV_C6 = 17'd47778
) (
  input logic clk,
  input logic rst,
  score_tone_seq_if.slave bus
);
  localparam int unsigned DW = $clog2((NOTE_CYC > GAP_CYC ? NOTE_CYC : GAP_CYC) + 1);
  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;
  state_t state;
  logic [7:0] score, prev_score;
  logic primed, vic, tone, evt, win;
  logic [1:0] idx;
  logic [DW-1:0] dur;
  logic [16:0] hc;
  assign score = {bus.tens, bus.units};
  assign evt = primed && score != prev_score;
  assign win = score == 8'h21;
  assign bus.audio = tone & ~bus.mute;
  function automatic logic [16:0] div_of(input logic [1:0] i);
    return i == 2'd0 ? DIV_C5 : i == 2'd1 ? DIV_E5 : i == 2'd2 ? DIV_G5 : DIV_C6;
  endfunction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      prev_score <= '0;
      primed <= 1'b0;
      vic <= 1'b0;
      tone <= 1'b0;
      idx <= '0;
      dur <= '0;
      hc <= '0;
      bus.note_div <= '0;
      bus.busy <= 1'b0;
      bus.seq_done <= 1'b0;
    end else begin
      prev_score <= score;
      primed <= 1'b1;
      bus.seq_done <= 1'b0;
      if (evt && (state == IDLE || win)) begin
        state <= PLAY;
        vic <= win;
        idx <= '0;
        dur <= '0;
        hc <= '0;
        tone <= 1'b0;
        bus.note_div <= DIV_C5;
        bus.busy <= 1'b1;
      end else if (state == PLAY) begin
        hc <= hc == bus.note_div - 17'd1 ? 17'd0 : hc + 17'd1;
        tone <= hc == bus.note_div - 17'd1 ? ~tone : tone;
        dur <= dur == DW'(NOTE_CYC - 1) ? '0 : dur + 1'b1;
        if (dur == DW'(NOTE_CYC - 1)) begin
          state <= GAP;
          hc <= '0;
          tone <= 1'b0;
          bus.note_div <= '0;
        end
      end else if (state == GAP) begin
        dur <= dur == DW'(GAP_CYC - 1) ? '0 : dur + 1'b1;
        if (dur == DW'(GAP_CYC - 1)) begin
          if (idx == (vic ? 2'd3 : 2'd1)) begin
            state <= IDLE;
            bus.busy <= 1'b0;
            bus.seq_done <= 1'b1;
          end else begin
            state <= PLAY;
            idx <= idx + 2'd1;
            hc <= '0;
            tone <= 1'b0;
            bus.note_div <= div_of(idx + 2'd1);
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_score_tone_seq.sv
// tb_score_tone_seq: scoreboard bench comparing every cycle against a timeline model
module tb_score_tone_seq;
  localparam int NOTE = 8;
  localparam int GAP = 4;
  localparam int PER = NOTE + GAP;
  localparam logic [16:0] DC5 = 17'd3;
  localparam logic [16:0] DE5 = 17'd5;
  localparam logic [16:0] DG5 = 17'd6;
  localparam logic [16:0] DC6 = 17'd4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  score_tone_seq_if bus();
  score_tone_seq #(
    .NOTE_CYC(NOTE), .GAP_CYC(GAP),
    .DIV_C5(DC5), .DIV_E5(DE5), .DIV_G5(DG5), .DIV_C6(DC6)
  ) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  typedef struct packed {
    logic [16:0] nd;
    logic a;
    logic b;
    logic d;
  } exp_t;
  exp_t q[$];
  logic [16:0] div_tab [4];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int s_start = 0;
  int s_n = 0;
  bit s_act = 0;
  bit primed_m = 0;
  logic [7:0] prev_m = '0;
  logic [7:0] cur_sc = 8'h07;
  task automatic chk(input string n, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", n, cyc, act, req);
    end
  endtask
  task automatic model(input logic [7:0] sc, input logic mu, input bit r);
    exp_t e;
    int el, w;
    bit bsy;
    e = '0;
    if (r) begin
      s_act = 0;
      primed_m = 0;
      q.push_back(e);
      return;
    end
    el = cyc - s_start;
    bsy = s_act && el >= 0 && el < s_n * PER;
    if (bsy) begin
      e.b = 1'b1;
      w = el % PER;
      if (w < NOTE) begin
        e.nd = div_tab[el / PER];
        e.a = ((w / int'(e.nd)) % 2 == 1) && !mu;
      end
    end
    e.d = s_act && el == s_n * PER;
    q.push_back(e);
    if (primed_m && sc != prev_m && (!bsy || sc == 8'h21)) begin
      s_act = 1;
      s_start = cyc + 1;
      s_n = sc == 8'h21 ? 4 : 2;
    end
    primed_m = 1;
    prev_m = sc;
  endtask
  task automatic tick(input logic [7:0] sc, input logic mu, input bit rv);
    @(posedge clk);
    #1;
    cyc++;
    cur_sc = sc;
    {bus.tens, bus.units} = sc;
    bus.mute = mu;
    if (rv && !rst) begin
      #1 rst = 1'b1;
      #1;
      chk("async_rst_busy", int'(bus.busy), 0);
      chk("async_rst_note_div", int'(bus.note_div), 0);
      chk("async_rst_audio", int'(bus.audio), 0);
      chk("async_rst_seq_done", int'(bus.seq_done), 0);
    end else
      rst = rv;
    model(sc, mu, rv);
  endtask
  task automatic hold(input int n, input logic mu);
    for (int i = 0; i < n; i++) tick(cur_sc, mu, 1'b0);
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("note_div", int'(bus.note_div), int'(e.nd));
      chk("busy", int'(bus.busy), int'(e.b));
      chk("seq_done", int'(bus.seq_done), int'(e.d));
      chk("audio", int'(bus.audio), int'(e.a));
    end
  end
  initial begin
    logic [7:0] ns;
    div_tab[0] = DC5;
    div_tab[1] = DE5;
    div_tab[2] = DG5;
    div_tab[3] = DC6;
    {bus.tens, bus.units} = 8'h07;
    bus.mute = 1'b0;
    for (int i = 0; i < 3; i++) tick(8'h07, 1'b0, 1'b1);
    hold(6, 1'b0);
    tick(8'h08, 1'b0, 1'b0);
    hold(30, 1'b0);
    tick(8'h04, 1'b0, 1'b0);
    hold(30, 1'b0);
    tick(8'h05, 1'b0, 1'b0);
    hold(30, 1'b0);
    tick(8'h20, 1'b0, 1'b0);
    hold(30, 1'b0);
    tick(8'h21, 1'b0, 1'b0);
    hold(55, 1'b0);
    tick(8'h20, 1'b0, 1'b0);
    hold(14, 1'b0);
    tick(8'h21, 1'b0, 1'b0);
    hold(55, 1'b0);
    tick(8'h33, 1'b0, 1'b0);
    hold(5, 1'b0);
    tick(8'h34, 1'b0, 1'b0);
    hold(30, 1'b0);
    tick(8'h40, 1'b0, 1'b0);
    hold(24, 1'b0);
    tick(8'h41, 1'b0, 1'b0);
    hold(30, 1'b0);
    tick(8'h50, 1'b1, 1'b0);
    hold(30, 1'b1);
    tick(8'h51, 1'b0, 1'b0);
    hold(10, 1'b0);
    tick(cur_sc, 1'b0, 1'b1);
    tick(cur_sc, 1'b0, 1'b1);
    hold(20, 1'b0);
    tick(8'h52, 1'b0, 1'b0);
    hold(30, 1'b0);
    for (int i = 0; i < 600; i++) begin
      ns = cur_sc;
      if ($urandom_range(0, 9) == 0)
        ns = $urandom_range(0, 2) == 0 ? 8'h21 : {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      tick(ns, $urandom_range(0, 3) == 0, 1'b0);
    end
    hold(60, 1'b0);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
